// File: rtl/uart_16550_regs_pkg.sv
// Shared types and constants for the 16550 register front end and the TX path.
package uart_16550_regs_pkg;

    // LCR field layout, MSB first.
    typedef struct packed {
        logic       dlab;
        logic       set_break;
        logic       force_parity;
        logic       even_parity;
        logic       parity_en;
        logic       stop_bits;
        logic [1:0] word_length;
    } lcr_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } uart_tx_state_e;

    // Stop-bit durations in baud ticks: 1, 1.5 and 2 bit times.
    localparam int STOP_TICKS_1   = 16;
    localparam int STOP_TICKS_1P5 = 24;
    localparam int STOP_TICKS_2   = 32;

    // 1.5 stop bits only exist for 5-bit words; other widths get 2.
    function automatic int stop_ticks(input lcr_t l);
        if (!l.stop_bits) begin
            return STOP_TICKS_1;
        end
        return (l.word_length == 2'd0) ? STOP_TICKS_1P5 : STOP_TICKS_2;
    endfunction

    // Parity over the active data bits only; stick parity sends ~even_parity.
    function automatic logic parity_bit(input logic [7:0] data, input lcr_t l);
        logic [7:0] mask;
        logic       x;
        mask = ~(8'hE0 << l.word_length);
        x    = ^(data & mask);
        if (l.force_parity) begin
            return ~l.even_parity;
        end
        return l.even_parity ? x : ~x;
    endfunction

endpackage

// File: rtl/uart_16550_tx_fifo.sv
// Synchronous FIFO with a single-entry mode, synchronous clear and level
// output. Shared by the TX and RX paths.
module uart_16550_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             single,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic             wr_drop
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             drop_q, drop_d;
    logic [LW-1:0]    cap;
    logic             full;
    logic             wr_ok;
    logic             rd_ok;

    assign cap     = single ? LW'(1) : LW'(DEPTH);
    assign full    = (level_q == cap);
    assign empty   = (level_q == '0);
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;
    assign wr_drop = drop_q;

    // A pop frees a slot in the same cycle, so a full buffer still accepts
    // a write that coincides with a read. Clear wins over everything.
    assign wr_ok = wr_en && !clear && (!full || rd_en);
    assign rd_ok = rd_en && !empty && !clear;

    // Next-state for pointers, occupancy, storage and drop pulse.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = wr_en && !clear && full && !rd_en;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            level_d = level_q + LW'(wr_ok) - LW'(rd_ok);
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_16550_tx.sv
// 16550 transmit serializer: buffers THR writes and shifts frames out on tx.
//
// state  | meaning
// IDLE   | line high, waiting for a baud tick with data buffered
// START  | start bit (low)
// DATA   | 5..8 data bits, LSB first
// PARITY | optional parity bit
// STOP   | stop bit(s), 1 / 1.5 / 2 bit times
module uart_16550_tx
    import uart_16550_regs_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          baud_tick,
    input  logic          thr_wr,
    input  logic [7:0]    thr_data,
    input  logic          fifo_en,
    input  logic          tx_fifo_reset,
    input  lcr_t          lcr,
    output logic          tx,
    output logic          thr_empty,
    output logic          tx_empty,
    output logic [LW-1:0] tx_level,
    output logic          wr_drop
);

    localparam logic [4:0] BIT_LAST = 5'(OVERSAMPLE - 1);

    uart_tx_state_e state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic           pen_q, pen_d;
    logic [1:0]     wl_q, wl_d;
    logic [4:0]     stop_last_q, stop_last_d;
    logic           tx_q, tx_d;
    logic           fifo_en_q;
    logic           pop;
    logic           load_frame;
    logic           fifo_clear;
    logic           fifo_empty;
    logic [7:0]     fifo_head;
    logic [2:0]     data_last;

    // Toggling fifo_en flushes the buffer just like an explicit FCR reset.
    assign fifo_clear = tx_fifo_reset | (fifo_en ^ fifo_en_q);

    uart_16550_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (fifo_clear),
        .single  (~fifo_en),
        .wr_en   (thr_wr),
        .wr_data (thr_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .level   (tx_level),
        .wr_drop (wr_drop)
    );

    assign data_last = 3'd4 + 3'(wl_q);
    assign thr_empty = fifo_empty;
    assign tx_empty  = fifo_empty && (state_q == TX_IDLE);
    // Break overrides from the live LCR; the FSM keeps draining underneath.
    assign tx        = lcr.set_break ? 1'b0 : tx_q;

    // Next-state, bit timing and serial data selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        pen_d       = pen_q;
        wl_d        = wl_q;
        stop_last_d = stop_last_q;
        tx_d        = tx_q;
        pop         = 1'b0;
        load_frame  = 1'b0;

        if (state_q == TX_IDLE) begin
            tx_d = 1'b1;
            if (baud_tick && !fifo_empty) begin
                load_frame = 1'b1;
            end
        end else if (baud_tick) begin
            if (cnt_q != 5'd0) begin
                cnt_d = cnt_q - 5'd1;
            end else begin
                case (state_q)
                    TX_START: begin
                        state_d = TX_DATA;
                        bit_d   = 3'd0;
                        tx_d    = shift_q[0];
                        cnt_d   = BIT_LAST;
                    end
                    TX_DATA: begin
                        if (bit_q == data_last) begin
                            if (pen_q) begin
                                state_d = TX_PARITY;
                                tx_d    = par_q;
                                cnt_d   = BIT_LAST;
                            end else begin
                                state_d = TX_STOP;
                                tx_d    = 1'b1;
                                cnt_d   = stop_last_q;
                            end
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = shift_q >> 1;
                            tx_d    = shift_q[1];
                            cnt_d   = BIT_LAST;
                        end
                    end
                    TX_PARITY: begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                        cnt_d   = stop_last_q;
                    end
                    TX_STOP: begin
                        if (!fifo_empty) begin
                            load_frame = 1'b1;
                        end else begin
                            state_d = TX_IDLE;
                            tx_d    = 1'b1;
                        end
                    end
                    default: begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                endcase
            end
        end

        // Frame format is frozen at pop time so LCR writes never corrupt it.
        if (load_frame) begin
            pop         = 1'b1;
            shift_d     = fifo_head;
            par_d       = parity_bit(fifo_head, lcr);
            pen_d       = lcr.parity_en;
            wl_d        = lcr.word_length;
            stop_last_d = 5'(stop_ticks(lcr) - 1);
            state_d     = TX_START;
            cnt_d       = BIT_LAST;
            tx_d        = 1'b0;
        end
    end

    // State register; reset drives the line idle-high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            pen_q       <= 1'b0;
            wl_q        <= '0;
            stop_last_q <= '0;
            tx_q        <= 1'b1;
            fifo_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            pen_q       <= pen_d;
            wl_q        <= wl_d;
            stop_last_q <= stop_last_d;
            tx_q        <= tx_d;
            fifo_en_q   <= fifo_en;
        end
    end

endmodule

// File: tb/tb_uart_16550_tx.sv
// Bench for uart_16550_tx: frame-level reference model plus literal frame pins.
module tb_uart_16550_tx;
    import uart_16550_regs_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick = 1'b0;
    logic       thr_wr;
    logic [7:0] thr_data;
    logic       fifo_en;
    logic       tx_fifo_reset;
    lcr_t       lcr;
    logic       tx, thr_empty, tx_empty, wr_drop;
    logic [4:0] tx_level;

    int checks = 0;
    int errors = 0;

    uart_16550_tx dut (
        .clk           (clk),
        .rst           (rst),
        .baud_tick     (baud_tick),
        .thr_wr        (thr_wr),
        .thr_data      (thr_data),
        .fifo_en       (fifo_en),
        .tx_fifo_reset (tx_fifo_reset),
        .lcr           (lcr),
        .tx            (tx),
        .thr_empty     (thr_empty),
        .tx_empty      (tx_empty),
        .tx_level      (tx_level),
        .wr_drop       (wr_drop)
    );

    always #5 clk = ~clk;

    int tick_period = 4;
    int div = 0;
    always @(posedge clk) begin
        #1;
        if (div >= tick_period - 1) begin
            div = 0;
            baud_tick = 1'b1;
        end else begin
            div++;
            baud_tick = 1'b0;
        end
    end

    logic tick_seen = 1'b0;
    always @(posedge clk) tick_seen <= baud_tick;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frames as lists of (level, ticks) ----
    typedef struct { logic v; int n; } seg_t;
    byte unsigned mq[$];
    seg_t         segs[$];
    int           seg_left;
    bit           busy;
    logic         m_tx;
    bit           m_drop;
    logic         fen_prev;
    int           m_sz, m_cap;
    bit           m_popped, m_clr;

    function automatic void build_frame(input byte unsigned b, input lcr_t l);
        int   nb;
        int   ones;
        logic pv;
        nb   = 5 + int'(l.word_length);
        ones = 0;
        segs.delete();
        segs.push_back('{1'b0, 16});
        for (int i = 0; i < nb; i++) begin
            segs.push_back('{b[i], 16});
            ones += int'(b[i]);
        end
        if (l.parity_en) begin
            if (l.force_parity) pv = !l.even_parity;
            else if (l.even_parity) pv = logic'(ones % 2);
            else pv = logic'((ones + 1) % 2);
            segs.push_back('{pv, 16});
        end
        if (!l.stop_bits) segs.push_back('{1'b1, 16});
        else if (nb == 5) segs.push_back('{1'b1, 24});
        else segs.push_back('{1'b1, 32});
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            segs.delete();
            busy     = 0;
            m_tx     = 1'b1;
            m_drop   = 0;
            fen_prev = 1'b0;
        end else begin
            m_sz     = mq.size();
            m_popped = 0;
            m_clr    = tx_fifo_reset || (fifo_en != fen_prev);
            fen_prev = fifo_en;
            m_cap    = fifo_en ? 16 : 1;
            if (baud_tick && busy) begin
                seg_left--;
                if (seg_left == 0) begin
                    void'(segs.pop_front());
                    if (segs.size() > 0) begin
                        seg_left = segs[0].n;
                        m_tx     = segs[0].v;
                    end else begin
                        busy = 0;
                        m_tx = 1'b1;
                    end
                end
            end
            if (baud_tick && !busy && m_sz > 0) begin
                build_frame(mq.pop_front(), lcr);
                m_popped = 1;
                busy     = 1;
                seg_left = segs[0].n;
                m_tx     = segs[0].v;
            end
            m_drop = 0;
            if (m_clr) mq.delete();
            else if (thr_wr) begin
                if (m_sz < m_cap || m_popped) mq.push_back(thr_data);
                else m_drop = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("tx", 32'(tx), 32'(lcr.set_break ? 1'b0 : m_tx));
            chk("thr_empty", 32'(thr_empty), 32'(mq.size() == 0));
            chk("tx_empty", 32'(tx_empty), 32'(mq.size() == 0 && !busy));
            chk("tx_level", 32'(tx_level), 32'(mq.size()));
            chk("wr_drop", 32'(wr_drop), 32'(m_drop));
        end
    end

    // ---------------- helpers ------------------------------------------------
    int run_v[$], run_n[$], exp_v[$], exp_n[$];

    task automatic wr(input logic [7:0] b);
        @(posedge clk); #1;
        thr_wr = 1'b1; thr_data = b;
        @(posedge clk); #1;
        thr_wr = 1'b0;
    endtask

    task automatic wait_tx_low(input string nm);
        int n = 0;
        while (tx !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
        chk(nm, 32'(tx), 32'd0);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (tx_empty !== 1'b1 && n < 40000) begin @(negedge clk); n++; end
        chk(nm, 32'(tx_empty), 32'd1);
    endtask

    // Records constant-level runs of tx in baud ticks, from the start bit
    // until tx_empty rises.
    task automatic measure(input string nm);
        logic cur;
        int   len = 0;
        int   n   = 0;
        bit   done = 0;
        run_v.delete(); run_n.delete();
        wait_tx_low({nm, "_start"});
        cur = 1'b0;
        while (!done && n < 40000) begin
            @(negedge clk); n++;
            if (tick_seen) begin
                len++;
                if (tx !== cur) begin
                    run_v.push_back(int'(cur)); run_n.push_back(len);
                    cur = tx; len = 0;
                end else if (tx_empty) begin
                    run_v.push_back(int'(cur)); run_n.push_back(len);
                    done = 1;
                end
            end
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic check_runs(input string nm);
        chk({nm, "_nruns"}, run_v.size(), exp_v.size());
        for (int i = 0; i < exp_v.size() && i < run_v.size(); i++) begin
            chk($sformatf("%s_v%0d", nm, i), run_v[i], exp_v[i]);
            chk($sformatf("%s_n%0d", nm, i), run_n[i], exp_n[i]);
        end
    endtask

    task automatic frame_test(input string nm, input logic [7:0] l, input logic [7:0] b);
        @(posedge clk); #1;
        lcr = lcr_t'(l);
        wr(b);
        measure(nm);
        check_runs(nm);
    endtask

    // ---------------- stimulus ------------------------------------------------
    initial begin
        int total;
        int r;
        rst = 1'b1; thr_wr = 1'b0; thr_data = 8'h00; fifo_en = 1'b0;
        tx_fifo_reset = 1'b0; lcr = lcr_t'(8'h03);
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_thr_empty", 32'(thr_empty), 32'd1);
        chk("rst_tx_empty", 32'(tx_empty), 32'd1);
        chk("rst_level", 32'(tx_level), 32'd0);
        chk("rst_drop", 32'(wr_drop), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (4) @(posedge clk);

        exp_v = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        exp_n = '{16, 16, 16, 16, 16, 16, 16, 16, 16, 16};
        frame_test("f8n1_55", 8'h03, 8'h55);
        exp_v = '{0, 1, 0, 1}; exp_n = '{16, 48, 80, 32};
        frame_test("f8e1_07", 8'h1B, 8'h07);
        exp_v = '{0, 1, 0, 1}; exp_n = '{16, 48, 96, 16};
        frame_test("f8o1_07", 8'h0B, 8'h07);
        exp_v = '{0, 1, 0, 1}; exp_n = '{16, 48, 80, 32};
        frame_test("fstick_07", 8'h2B, 8'h07);
        exp_v = '{0, 1}; exp_n = '{96, 24};
        frame_test("f5_stop15", 8'h04, 8'h00);
        exp_v = '{0, 1}; exp_n = '{144, 32};
        frame_test("f8_stop2", 8'h07, 8'h00);

        // FIFO fill: 17 writes before any tick, then back-to-back drain.
        wait_idle("pre_fifo_idle");
        tick_period = 100;
        @(posedge clk); #1; lcr = lcr_t'(8'h03); fifo_en = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) begin
            thr_wr = 1'b1; thr_data = 8'($urandom);
            @(posedge clk); #1;
        end
        thr_wr = 1'b0;
        @(negedge clk);
        chk("fill_drop", 32'(wr_drop), 32'd1);
        chk("fill_level", 32'(tx_level), 32'd16);
        tick_period = 4;
        measure("b2b");
        total = 0;
        foreach (run_n[i]) total += run_n[i];
        chk("b2b_ticks", total, 32'd2560);

        // Holding-register mode drop, then FIFO reset mid-frame.
        @(posedge clk); #1; fifo_en = 1'b0;
        wr(8'($urandom));
        wait_tx_low("hold_start");
        wr(8'hA5);
        wr(8'h3C);
        @(negedge clk);
        chk("hold_drop", 32'(wr_drop), 32'd1);
        chk("hold_level", 32'(tx_level), 32'd1);
        @(posedge clk); #1; tx_fifo_reset = 1'b1;
        @(posedge clk); #1; tx_fifo_reset = 1'b0;
        @(negedge clk);
        chk("flush_thr_empty", 32'(thr_empty), 32'd1);
        wait_idle("flush_idle");

        // Break during data bits of an all-ones byte.
        wr(8'hFF);
        wait_tx_low("brk_start");
        repeat (100) @(negedge clk);
        @(posedge clk); #1; lcr.set_break = 1'b1;
        repeat (20) begin @(negedge clk); chk("brk_low", 32'(tx), 32'd0); end
        @(posedge clk); #1; lcr.set_break = 1'b0;
        @(negedge clk);
        chk("brk_release", 32'(tx), 32'd1);
        wait_idle("brk_idle");

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            thr_wr = 1'b0; tx_fifo_reset = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 45) begin thr_wr = 1'b1; thr_data = 8'($urandom); end
            else if (r < 48) tx_fifo_reset = 1'b1;
            else if (r < 50) fifo_en = ~fifo_en;
            else if (r < 56) lcr = lcr_t'(8'($urandom_range(0, 63)));
            else if (r < 58) lcr.set_break = ~lcr.set_break;
            else if (r < 60) tick_period = $urandom_range(1, 5);
            else if (r >= 92) repeat ($urandom_range(1, 40)) @(posedge clk);
        end
        @(posedge clk); #1;
        thr_wr = 1'b0; tx_fifo_reset = 1'b0; lcr.set_break = 1'b0; tick_period = 2;
        wait_idle("rand_idle");

        // Asynchronous reset in the middle of a frame.
        @(posedge clk); #1; fifo_en = 1'b1; lcr = lcr_t'(8'h03); tick_period = 4;
        @(posedge clk); #1;
        wr(8'h00); wr(8'h81); wr(8'h42);
        wait_tx_low("arst_start");
        repeat (50) @(negedge clk);
        #2; rst = 1'b1;
        #1;
        chk("arst_tx", 32'(tx), 32'd1);
        chk("arst_thr_empty", 32'(thr_empty), 32'd1);
        chk("arst_tx_empty", 32'(tx_empty), 32'd1);
        chk("arst_level", 32'(tx_level), 32'd0);
        chk("arst_drop", 32'(wr_drop), 32'd0);
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        repeat (20) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
